// File: rtl/io_seg_driver.sv
// io_seg_driver: 8-digit multiplexed common-anode seven-segment controller; optional SEG_LEADING_ZERO_BLANK_EN blanks leading zeros
module io_seg_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DigitalCtrl,
  input  logic        IOWrite,
  input  logic [3:0]  addr,
  input  logic [31:0] write_data,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [7:0] hex_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  logic          wr;
  logic          wrap;
  logic          lit;
  logic [3:0]    nib;
  logic [7:0]    en_nxt;
  logic [31:0]   disp;
  logic [7:0]    mask;
  logic [PW-1:0] pcnt;
  logic [2:0]    idx;
  logic          unused_hi;
  assign unused_hi = ^write_data[31:16];
  always_comb begin
    wr = DigitalCtrl & IOWrite;
    wrap = pcnt == PW'(SCAN_DIV - 1);
    nib = disp[{idx, 2'b00} +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    lit = mask[idx] & ((idx == 3'd0) | ((disp >> {idx, 2'b00}) != 32'd0));
`else
    lit = mask[idx];
`endif
    en_nxt = lit ? ~(8'b1 << idx) : 8'hFF;
  end
  // outputs are built from the pre-edge index and data, so select and segments move together
  always_ff @(posedge clk) begin
    if (rst) begin
      disp    <= '0;
      mask    <= 8'hFF;
      pcnt    <= '0;
      idx     <= '0;
      seg_en  <= 8'hFF;
      seg_out <= 8'hFF;
    end else begin
      if (wr && addr == 4'h0) disp[15:0] <= write_data[15:0];
      if (wr && addr == 4'h2) disp[31:16] <= write_data[15:0];
      if (wr && addr == 4'h4) mask <= write_data[7:0];
      pcnt    <= wrap ? '0 : pcnt + 1'b1;
      idx     <= idx + 3'(wrap);
      seg_en  <= en_nxt;
      seg_out <= hex_tab[nib];
    end
  end
endmodule

// File: tb/tb_io_seg_driver.sv
// tb_io_seg_driver: table vectors, directed corner sequences and random traffic checked against a slot-arithmetic model
module tb_io_seg_driver;
  localparam int SCAN_DIV = 4;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] EN1_ZERO = 8'hFF;
`else
  localparam logic [7:0] EN1_ZERO = 8'hFD;
`endif
  localparam logic [7:0] seven [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  typedef struct {
    logic        r;
    logic        dc;
    logic        iow;
    logic [3:0]  a;
    logic [31:0] d;
    logic [7:0]  en;
    logic [7:0]  out;
  } vec_t;
  logic        clk = 0;
  logic        rst = 1;
  logic        DigitalCtrl = 0;
  logic        IOWrite = 0;
  logic [3:0]  addr = 0;
  logic [31:0] write_data = 0;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;
  logic [31:0] m_disp = 0;
  logic [7:0]  m_mask = 8'hFF;
  int          t = 0;
  int          tests = 0;
  int          fails = 0;
  string       phase = "reset";
  vec_t        vecs [12];

  io_seg_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .DigitalCtrl(DigitalCtrl), .IOWrite(IOWrite),
    .addr(addr), .write_data(write_data), .seg_en(seg_en), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s/%s: got %h expected %h (t=%0d)", phase, name, act, exp, t);
    end
  endtask

  task automatic step(input logic r, input logic dc, input logic iow, input logic [3:0] a, input logic [31:0] d);
    logic [7:0] e_en, e_out;
    logic lit;
    int i;
    rst = r; DigitalCtrl = dc; IOWrite = iow; addr = a; write_data = d;
    e_en = 8'hFF; e_out = 8'hFF;
    if (!r) begin
      i = (t / SCAN_DIV) % 8;
      lit = m_mask[i];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (i > 0 && (m_disp >> (4 * i)) == 0) lit = 0;
`endif
      if (lit) e_en[i] = 1'b0;
      e_out = seven[(m_disp >> (4 * i)) & 32'hF];
    end
    if (r) begin
      m_disp = 0; m_mask = 8'hFF; t = 0;
    end else begin
      if (dc && iow) begin
        if (a == 4'h0) m_disp[15:0] = d[15:0];
        if (a == 4'h2) m_disp[31:16] = d[15:0];
        if (a == 4'h4) m_mask = d[7:0];
      end
      t++;
    end
    @(posedge clk);
    #1;
    check("seg_en", seg_en, e_en);
    check("seg_out", seg_out, e_out);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 0, 8'hFF, 8'hFF};
    vecs[1]  = '{1, 0, 0, 0, 0, 8'hFF, 8'hFF};
    vecs[2]  = '{1, 0, 0, 0, 0, 8'hFF, 8'hFF};
    vecs[3]  = '{0, 0, 0, 0, 0, 8'hFE, 8'hC0};
    vecs[4]  = '{0, 0, 0, 0, 0, 8'hFE, 8'hC0};
    vecs[5]  = '{0, 0, 0, 0, 0, 8'hFE, 8'hC0};
    vecs[6]  = '{0, 0, 0, 0, 0, 8'hFE, 8'hC0};
    vecs[7]  = '{0, 0, 0, 0, 0, EN1_ZERO, 8'hC0};
    vecs[8]  = '{0, 1, 1, 4'h0, 32'hFFFF_1234, EN1_ZERO, 8'hC0};
    vecs[9]  = '{0, 0, 0, 0, 0, 8'hFD, 8'hB0};
    vecs[10] = '{0, 0, 0, 0, 0, 8'hFD, 8'hB0};
    vecs[11] = '{0, 0, 0, 0, 0, 8'hFB, 8'hA4};
    phase = "table";
    for (int v = 0; v < 12; v++) begin
      step(vecs[v].r, vecs[v].dc, vecs[v].iow, vecs[v].a, vecs[v].d);
      check("vec_en", seg_en, vecs[v].en);
      check("vec_out", seg_out, vecs[v].out);
    end
    phase = "write_hi";
    step(0, 1, 1, 4'h2, 32'h0000_ABCD);
    idle(8 * SCAN_DIV);
    phase = "ignored";
    step(0, 0, 1, 4'h0, 32'h0000_FFFF);
    step(0, 1, 1, 4'h6, 32'h0000_FFFF);
    step(0, 1, 0, 4'h2, 32'h0000_FFFF);
    idle(8 * SCAN_DIV);
    phase = "mask";
    step(0, 1, 1, 4'h4, 32'h0000_000F);
    idle(8 * SCAN_DIV);
    phase = "slot_change_write";
    for (int k = 0; k < 2 * SCAN_DIV && (t % SCAN_DIV) != SCAN_DIV - 1; k++) idle(1);
    step(0, 1, 1, 4'h0, 32'h0000_9876);
    idle(2 * SCAN_DIV);
    phase = "reset_mid_scan";
    step(0, 1, 1, 4'h4, 32'h0000_00FF);
    for (int k = 0; k < 8 * SCAN_DIV && ((t / SCAN_DIV) % 8) != 5; k++) idle(1);
    check("at_idx5", 8'(((t / SCAN_DIV) % 8)), 8'd5);
    step(1, 1, 1, 4'h0, 32'h0000_5555);
    check("rst_en", seg_en, 8'hFF);
    check("rst_out", seg_out, 8'hFF);
    idle(8 * SCAN_DIV);
    phase = "leading_zero";
    step(0, 1, 1, 4'h0, 32'h0000_0120);
    step(0, 1, 1, 4'h2, 32'h0000_0000);
    idle(8 * SCAN_DIV);
    step(0, 1, 1, 4'h0, 32'h0000_0000);
    idle(8 * SCAN_DIV);
    phase = "random";
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] a;
      case ($urandom_range(3))
        0: a = 4'h0;
        1: a = 4'h2;
        2: a = 4'h4;
        default: a = 4'($urandom_range(15));
      endcase
      step($urandom_range(63) == 0, 1'($urandom_range(1)), 1'($urandom_range(1)), a, $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
